// File: rtl/ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe_if
// Brief    : Decoded-control and stage-aligned control bundle for ctrl_pipe.
// Revision : 1.0 - initial release
// ============================================================================
interface ctrl_pipe_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic             id_alusrc;
    logic             id_memtoreg;
    logic             id_regwrite;
    logic             id_memread;
    logic             id_memwrite;
    logic             id_branch;
    logic [1:0]       id_aluop;
    logic [4:0]       id_rd;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             ex_zero;

    logic             stall;
    logic             flush;
    logic             ex_valid;
    logic             ex_alusrc;
    logic             ex_branch;
    logic             ex_memread;
    logic             ex_memwrite;
    logic             ex_regwrite;
    logic             ex_memtoreg;
    logic [1:0]       ex_aluop;
    logic [4:0]       ex_rd;
    logic             mem_memread;
    logic             mem_memwrite;
    logic             mem_regwrite;
    logic             mem_memtoreg;
    logic [4:0]       mem_rd;
    logic             wb_regwrite;
    logic             wb_memtoreg;
    logic [4:0]       wb_rd;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread,
               id_memwrite, id_branch, id_aluop, id_rd, id_rs1, id_rs2, ex_zero,
        input  stall, flush, ex_valid, ex_alusrc, ex_branch, ex_memread,
               ex_memwrite, ex_regwrite, ex_memtoreg, ex_aluop, ex_rd,
               mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, mem_rd,
               wb_regwrite, wb_memtoreg, wb_rd, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread,
               id_memwrite, id_branch, id_aluop, id_rd, id_rs1, id_rs2, ex_zero,
        output stall, flush, ex_valid, ex_alusrc, ex_branch, ex_memread,
               ex_memwrite, ex_regwrite, ex_memtoreg, ex_aluop, ex_rd,
               mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg, mem_rd,
               wb_regwrite, wb_memtoreg, wb_rd, stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pipe
// Brief    : ID->EX->MEM->WB control pipeline with load-use stall, taken-branch
//            squash and saturating stall/flush event counters.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe #(
    parameter int CNT_W = 16
) (
    input  wire logic   clk,
    input  wire logic   rst,
    ctrl_pipe_if.slave  bus
);

    typedef struct packed {
        logic       valid;
        logic       alusrc;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
        logic [1:0] aluop;
        logic [4:0] rd;
    } ex_word_t;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
        logic [4:0] rd;
    } mem_word_t;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic [4:0] rd;
    } wb_word_t;

    localparam logic [4:0] c_x0 = 5'd0;

    ex_word_t         ex_q, ex_d;
    mem_word_t        mem_q, mem_d;
    wb_word_t         wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic w_taken;
    logic w_hazard;
    logic w_stall;

    always_comb begin
        w_taken  = ex_q.valid & ex_q.branch & bus.ex_zero;
        w_hazard = bus.id_valid & ex_q.valid & ex_q.memread & (ex_q.rd != c_x0) &
                   ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));
        // The ID instruction is wrong-path on a taken branch, so stalling it is pointless.
        w_stall  = w_hazard & ~w_taken;
    end

    always_comb begin
        ex_d = '0;
        if (!(w_taken || w_hazard || !bus.id_valid)) begin
            ex_d.valid    = 1'b1;
            ex_d.alusrc   = bus.id_alusrc;
            ex_d.branch   = bus.id_branch;
            ex_d.memread  = bus.id_memread;
            ex_d.memwrite = bus.id_memwrite;
            ex_d.regwrite = bus.id_regwrite & (bus.id_rd != c_x0);
            ex_d.memtoreg = bus.id_memtoreg;
            ex_d.aluop    = bus.id_aluop;
            ex_d.rd       = bus.id_rd;
        end

        mem_d.memread  = ex_q.memread;
        mem_d.memwrite = ex_q.memwrite;
        mem_d.regwrite = ex_q.regwrite;
        mem_d.memtoreg = ex_q.memtoreg;
        mem_d.rd       = ex_q.rd;

        wb_d.regwrite  = mem_q.regwrite;
        wb_d.memtoreg  = mem_q.memtoreg;
        wb_d.rd        = mem_q.rd;

        stall_cnt_d = stall_cnt_q;
        if (w_stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (w_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.flush        = w_taken;
    assign bus.ex_valid     = ex_q.valid;
    assign bus.ex_alusrc    = ex_q.alusrc;
    assign bus.ex_branch    = ex_q.branch;
    assign bus.ex_memread   = ex_q.memread;
    assign bus.ex_memwrite  = ex_q.memwrite;
    assign bus.ex_regwrite  = ex_q.regwrite;
    assign bus.ex_memtoreg  = ex_q.memtoreg;
    assign bus.ex_aluop     = ex_q.aluop;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.mem_memread  = mem_q.memread;
    assign bus.mem_memwrite = mem_q.memwrite;
    assign bus.mem_regwrite = mem_q.regwrite;
    assign bus.mem_memtoreg = mem_q.memtoreg;
    assign bus.mem_rd       = mem_q.rd;
    assign bus.wb_regwrite  = wb_q.regwrite;
    assign bus.wb_memtoreg  = wb_q.memtoreg;
    assign bus.wb_rd        = wb_q.rd;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_pipe
// Brief    : Self-checking bench for ctrl_pipe (CNT_W=16 and CNT_W=2 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

    // control field order: {alusrc, memtoreg, regwrite, memread, memwrite, branch}
    localparam logic [5:0] c_ctl_add  = 6'b001000;
    localparam logic [5:0] c_ctl_addi = 6'b101000;
    localparam logic [5:0] c_ctl_lw   = 6'b111100;
    localparam logic [5:0] c_ctl_beq  = 6'b000001;
    localparam logic [5:0] c_ctl_ldbr = 6'b000101;

    typedef struct {
        logic       v;
        logic [5:0] ctl;
        logic [1:0] op;
        logic [4:0] rd, rs1, rs2;
        logic       z;
    } in_t;

    typedef struct {
        in_t        in;
        logic       e_stall, e_flush, e_exv;
        logic [4:0] e_exrd;
        int         e_sc, e_fc;
    } vec_t;

    typedef struct {
        logic       v, alusrc, memtoreg, regwrite, memread, memwrite, branch;
        logic [1:0] op;
        logic [4:0] rd;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.CNT_W(16)) bus1 ();
    ctrl_pipe_if #(.CNT_W(2))  bus2 ();

    ctrl_pipe #(.CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus1));
    ctrl_pipe #(.CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(bus2));

    assign bus2.id_valid    = bus1.id_valid;
    assign bus2.id_alusrc   = bus1.id_alusrc;
    assign bus2.id_memtoreg = bus1.id_memtoreg;
    assign bus2.id_regwrite = bus1.id_regwrite;
    assign bus2.id_memread  = bus1.id_memread;
    assign bus2.id_memwrite = bus1.id_memwrite;
    assign bus2.id_branch   = bus1.id_branch;
    assign bus2.id_aluop    = bus1.id_aluop;
    assign bus2.id_rd       = bus1.id_rd;
    assign bus2.id_rs1      = bus1.id_rs1;
    assign bus2.id_rs2      = bus1.id_rs2;
    assign bus2.ex_zero     = bus1.ex_zero;

    int    n_checks = 0;
    int    n_errors = 0;
    in_t   cur;
    word_t m_ex, m_mem, m_wb;
    int    m_sc, m_fc;
    vec_t  vecs[23];
    int    sat_exp[5];

    function automatic in_t mk(logic v, logic [5:0] ctl, logic [1:0] op,
                               logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2, logic z);
        in_t r;
        r.v = v; r.ctl = ctl; r.op = op; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.z = z;
        return r;
    endfunction

    function automatic logic [31:0] sat(int v, int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_ex = '{default: '0}; m_mem = '{default: '0}; m_wb = '{default: '0};
        m_sc = 0; m_fc = 0;
    endtask

    function automatic logic pred_taken();
        return m_ex.v & m_ex.branch & cur.z;
    endfunction

    function automatic logic pred_hazard();
        return cur.v & m_ex.v & m_ex.memread & (m_ex.rd != 0) &
               ((m_ex.rd == cur.rs1) | (m_ex.rd == cur.rs2));
    endfunction

    // Drive cur, let the combinational outputs settle, compare everything to the model.
    task automatic drive_and_check();
        logic t, h;
        bus1.id_valid    = cur.v;
        {bus1.id_alusrc, bus1.id_memtoreg, bus1.id_regwrite,
         bus1.id_memread, bus1.id_memwrite, bus1.id_branch} = cur.ctl;
        bus1.id_aluop    = cur.op;
        bus1.id_rd       = cur.rd;
        bus1.id_rs1      = cur.rs1;
        bus1.id_rs2      = cur.rs2;
        bus1.ex_zero     = cur.z;
        #3;
        t = pred_taken();
        h = pred_hazard();
        chk("stall", 32'(bus1.stall), 32'(h & ~t));
        chk("flush", 32'(bus1.flush), 32'(t));
        chk("ex_word",
            32'({bus1.ex_valid, bus1.ex_alusrc, bus1.ex_branch, bus1.ex_memread,
                 bus1.ex_memwrite, bus1.ex_regwrite, bus1.ex_memtoreg, bus1.ex_aluop, bus1.ex_rd}),
            32'({m_ex.v, m_ex.alusrc, m_ex.branch, m_ex.memread,
                 m_ex.memwrite, m_ex.regwrite, m_ex.memtoreg, m_ex.op, m_ex.rd}));
        chk("mem_word",
            32'({bus1.mem_memread, bus1.mem_memwrite, bus1.mem_regwrite, bus1.mem_memtoreg, bus1.mem_rd}),
            32'({m_mem.memread, m_mem.memwrite, m_mem.regwrite, m_mem.memtoreg, m_mem.rd}));
        chk("wb_word",
            32'({bus1.wb_regwrite, bus1.wb_memtoreg, bus1.wb_rd}),
            32'({m_wb.regwrite, m_wb.memtoreg, m_wb.rd}));
        chk("stall_cnt",    32'(bus1.stall_cnt), sat(m_sc, 65535));
        chk("flush_cnt",    32'(bus1.flush_cnt), sat(m_fc, 65535));
        chk("stall_cnt_w2", 32'(bus2.stall_cnt), sat(m_sc, 3));
        chk("flush_cnt_w2", 32'(bus2.flush_cnt), sat(m_fc, 3));
    endtask

    // Clock edge; the model takes the same edge using the spec's rules.
    task automatic advance();
        logic  t, h;
        word_t w;
        @(posedge clk);
        t = pred_taken();
        h = pred_hazard();
        w = '{default: '0};
        if (!(t || h || !cur.v)) begin
            w.v = 1'b1;
            {w.alusrc, w.memtoreg, w.regwrite, w.memread, w.memwrite, w.branch} = cur.ctl;
            w.regwrite = w.regwrite & (cur.rd != 0);
            w.op = cur.op;
            w.rd = cur.rd;
        end
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = w;
        if (h && !t) m_sc++;
        if (t)       m_fc++;
        #1;
    endtask

    task automatic step(in_t x);
        cur = x;
        drive_and_check();
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_clear();
        cur = mk(1, c_ctl_add, 2'b10, 5, 1, 2, 1);
        drive_and_check();
        @(posedge clk);
        #1;
        drive_and_check();
        cur = mk(0, 6'd0, 2'd0, 0, 0, 0, 0);
        drive_and_check();
        rst = 1'b0;
        advance();
    endtask

    initial begin
        vecs[0]  = '{mk(1, c_ctl_add,  2, 5, 1, 2, 0), 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{mk(0, 6'd0,       0, 0, 0, 0, 0), 0, 0, 1, 5, 0, 0};
        vecs[2]  = '{mk(0, 6'd0,       0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{mk(1, c_ctl_lw,   0, 3, 1, 0, 0), 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{mk(1, c_ctl_add,  2, 6, 3, 7, 0), 1, 0, 1, 3, 0, 0};
        vecs[5]  = '{mk(1, c_ctl_add,  2, 6, 3, 7, 0), 0, 0, 0, 0, 1, 0};
        vecs[6]  = '{mk(1, c_ctl_lw,   0, 0, 1, 0, 0), 0, 0, 1, 6, 1, 0};
        vecs[7]  = '{mk(1, c_ctl_add,  2, 7, 0, 0, 0), 0, 0, 1, 0, 1, 0};
        vecs[8]  = '{mk(1, c_ctl_addi, 0, 3, 2, 0, 0), 0, 0, 1, 7, 1, 0};
        vecs[9]  = '{mk(1, c_ctl_add,  2, 8, 3, 0, 0), 0, 0, 1, 3, 1, 0};
        vecs[10] = '{mk(1, c_ctl_beq,  1, 0, 1, 2, 0), 0, 0, 1, 8, 1, 0};
        vecs[11] = '{mk(1, c_ctl_add,  2, 9, 1, 0, 0), 0, 0, 1, 0, 1, 0};
        vecs[12] = '{mk(1, c_ctl_beq,  1, 0, 1, 2, 1), 0, 0, 1, 9, 1, 0};
        vecs[13] = '{mk(1, c_ctl_add,  2, 10, 1, 0, 1), 0, 1, 1, 0, 1, 0};
        vecs[14] = '{mk(1, c_ctl_ldbr, 0, 4, 0, 0, 0), 0, 0, 0, 0, 1, 1};
        vecs[15] = '{mk(1, c_ctl_add,  2, 11, 4, 0, 1), 0, 1, 1, 4, 1, 1};
        vecs[16] = '{mk(0, 6'd0,       0, 0, 0, 0, 0), 0, 0, 0, 0, 1, 2};
        vecs[17] = '{mk(1, c_ctl_lw,   0, 3, 1, 0, 0), 0, 0, 0, 0, 1, 2};
        vecs[18] = '{mk(1, c_ctl_lw,   0, 4, 3, 0, 0), 1, 0, 1, 3, 1, 2};
        vecs[19] = '{mk(1, c_ctl_lw,   0, 4, 3, 0, 0), 0, 0, 0, 0, 2, 2};
        vecs[20] = '{mk(1, c_ctl_add,  2, 5, 0, 4, 0), 1, 0, 1, 4, 2, 2};
        vecs[21] = '{mk(1, c_ctl_add,  2, 5, 0, 4, 0), 0, 0, 0, 0, 3, 2};
        vecs[22] = '{mk(0, 6'd0,       0, 0, 0, 0, 0), 0, 0, 1, 5, 3, 2};
        sat_exp  = '{1, 2, 3, 3, 3};

        @(posedge clk);
        #1;
        do_reset();

        // Reset then stream: ADD rd=5 walks EX, MEM, WB on successive edges.
        step(mk(1, c_ctl_add, 2'b10, 5, 1, 2, 0));
        cur = mk(0, 6'd0, 0, 0, 0, 0, 0);
        drive_and_check();
        chk("stream_ex_regwrite", 32'(bus1.ex_regwrite), 32'd1);
        chk("stream_ex_rd",       32'(bus1.ex_rd),       32'd5);
        advance();
        drive_and_check();
        chk("stream_mem_regwrite", 32'(bus1.mem_regwrite), 32'd1);
        advance();
        drive_and_check();
        chk("stream_wb_regwrite", 32'(bus1.wb_regwrite), 32'd1);
        chk("stream_wb_rd",       32'(bus1.wb_rd),       32'd5);
        advance();

        // Directed table.
        do_reset();
        for (int i = 0; i < 23; i++) begin
            cur = vecs[i].in;
            drive_and_check();
            chk($sformatf("vec%0d_stall", i), 32'(bus1.stall),     32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_flush", i), 32'(bus1.flush),     32'(vecs[i].e_flush));
            chk($sformatf("vec%0d_exv", i),   32'(bus1.ex_valid),  32'(vecs[i].e_exv));
            chk($sformatf("vec%0d_exrd", i),  32'(bus1.ex_rd),     32'(vecs[i].e_exrd));
            chk($sformatf("vec%0d_scnt", i),  32'(bus1.stall_cnt), 32'(vecs[i].e_sc));
            chk($sformatf("vec%0d_fcnt", i),  32'(bus1.flush_cnt), 32'(vecs[i].e_fc));
            advance();
        end

        // Saturation of the 2-bit counter over five load-use stalls.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(mk(1, c_ctl_lw, 0, 3, 1, 0, 0));
            step(mk(1, c_ctl_add, 2, 6, 3, 0, 0));
            cur = mk(1, c_ctl_add, 2, 6, 3, 0, 0);
            drive_and_check();
            chk($sformatf("sat%0d_w2", i), 32'(bus2.stall_cnt), 32'(sat_exp[i]));
            advance();
        end

        // Reset asserted mid-stall clears stall without a clock edge.
        do_reset();
        step(mk(1, c_ctl_lw, 0, 3, 1, 0, 0));
        cur = mk(1, c_ctl_add, 2, 6, 3, 0, 0);
        drive_and_check();
        chk("midstall_pre", 32'(bus1.stall), 32'd1);
        rst = 1'b1;
        #1;
        chk("midstall_stall", 32'(bus1.stall),    32'd0);
        chk("midstall_exv",   32'(bus1.ex_valid), 32'd0);
        chk("midstall_scnt",  32'(bus1.stall_cnt), 32'd0);
        do_reset();

        // Reset asserted mid-flush clears flush without a clock edge.
        step(mk(1, c_ctl_beq, 1, 0, 1, 2, 0));
        cur = mk(1, c_ctl_add, 2, 6, 1, 0, 1);
        drive_and_check();
        chk("midflush_pre", 32'(bus1.flush), 32'd1);
        rst = 1'b1;
        #1;
        chk("midflush_flush", 32'(bus1.flush), 32'd0);
        do_reset();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            step(mk(logic'($urandom_range(0, 9) != 0), 6'($urandom_range(0, 63)),
                    2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    logic'($urandom_range(0, 1))));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the decoded control word from the ID stage through the EX, MEM and WB pipeline registers of the pipelined RISC-V core. It consumes the main decoder's outputs and delivers stage-aligned control bits to the datapath. It detects load-use hazards and inserts bubbles. It squashes the wrong-path instruction on a taken branch, and keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush event counters

Ports:
- clk  in  1  core clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction; the decoder drives 0 for unsupported opcodes
- id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite, id_branch  in  1 each  decoded control bits
- id_aluop  in  2  decoded ALU operation class: 00 add, 01 sub/compare, 10 funct-decoded
- id_rd, id_rs1, id_rs2  in  5 each  register fields of the ID instruction
- ex_zero  in  1  ALU zero flag for the instruction currently in EX
- stall  out  1  hold PC and IF/ID this cycle
- flush  out  1  squash IF/ID this cycle, redirect PC to the branch target
- ex_valid, ex_alusrc, ex_branch, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg  out  1 each  EX-stage control
- ex_aluop  out  2;  ex_rd  out  5
- mem_memread, mem_memwrite, mem_regwrite, mem_memtoreg  out  1 each;  mem_rd  out  5
- wb_regwrite, wb_memtoreg  out  1 each;  wb_rd  out  5
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

## Operation
- Three register banks: ID→EX, EX→MEM, MEM→WB. All banks advance every cycle. There is no global enable.
- A bubble is all control bits 0, valid 0, and rd 0.
- The ID→EX capture gates id_regwrite with (id_rd != 0), so a write to x0 never propagates.
- Taken-branch detection, combinational: `taken = ex_valid & ex_branch & ex_zero`. `flush = taken`.
- Load-use hazard, combinational: `hazard = id_valid & ex_valid & ex_memread & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2)`.
- The stall output is `hazard & ~taken`. Flush has priority because the ID instruction is wrong-path.
- ID→EX next value:
  - bubble if taken, hazard, or ~id_valid;
  - otherwise the ID control word and id_rd.
- EX→MEM and MEM→WB always copy the previous stage. The bank copies only the fields that stage needs.
- stall_cnt increments on every cycle with stall=1. flush_cnt increments on every cycle with flush=1. Both saturate at all-ones and never wrap.

## Timing
- Reset, asynchronous:
  - all pipeline banks go to bubble;
  - all control outputs and rd fields are 0;
  - stall=0, flush=0;
  - both counters are 0.
- Release from reset: the first id_valid word appears on the ex_* outputs one edge later, on mem_* two edges later, and on wb_* three edges later.
- stall and flush are combinational from the EX bank and ex_zero. Both are valid within the cycle and have no registered delay.
- Load-use:
  - exactly one stall cycle is inserted;
  - after the bubble edge, ex_valid=0, so hazard drops and the held ID instruction advances on the next edge.
- Taken branch:
  - resolved in EX with a 2-instruction penalty;
  - this block squashes the ID instruction;
  - the external IF/ID flush squashes the IF instruction.
- Taken branch and hazard in the same cycle: flush=1, stall=0, ID→EX receives a bubble, and only flush_cnt increments.
- Back-to-back loads with dependent consumers each stall once. No extra cycle is added.
- Reset asserted mid-stall or mid-flush clears stall and flush immediately, without waiting for a clock edge.

## Test plan
- Reset then stream: assert and release rst, then send ADD (regwrite=1, aluop=10, rd=5). Required: ex_regwrite=1 and ex_rd=5 after 1 edge; mem_regwrite=1 after 2 edges; wb_regwrite=1 and wb_rd=5 after 3 edges. All outputs are 0 during reset.
- Load-use: send LW rd=3, then ADD rs1=3. Required: stall=1 for exactly one cycle, an ex_valid=0 bubble follows the LW, ADD reaches EX one cycle late, and stall_cnt=1.
- No false hazard:
  - LW rd=0 followed by a reader of x0: stall=0 throughout.
  - ADDI rd=3 followed by a reader of rs1=3: stall=0 throughout.
- Taken branch: BEQ in EX with ex_zero=1. Required: flush=1 for one cycle, the next ex_valid=0, and flush_cnt=1. With ex_zero=0, flush=0 and the following instruction proceeds.
- Flush beats stall: LW rd=4 sits in EX while a BEQ whose EX cycle coincides with an ID reader of x4 is arranged. Required: in the colliding cycle, stall=0 and flush=1, with a single bubble, flush_cnt=1 and stall_cnt unchanged.
- Counter saturation, run with CNT_W=2: force 5 load-use stalls. Required: stall_cnt reads 1,2,3,3,3.
